// File: rtl/onchip_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_arb_pkg
// Shared constants and types for the two-requester on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W : word-address, data and byte-lane widths
//   grant_t                : identifies which requester owns the RAM
//   avm_req_t              : one requester's Avalon-MM command, bundled
// -----------------------------------------------------------------------------
package onchip_mem_arb_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } avm_req_t;

  // A simultaneous read+write is serviced as a write, so the read flag is
  // cleared whenever write is asserted.
  function automatic avm_req_t normalize_req(input logic [ADDR_W-1:0] address,
                                             input logic [BE_W-1:0]   byteenable,
                                             input logic              read,
                                             input logic              write,
                                             input logic [DATA_W-1:0] writedata);
    avm_req_t r;
    r.address    = address;
    r.byteenable = byteenable;
    r.read       = read & ~write;
    r.write      = write;
    r.writedata  = writedata;
    return r;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter_if
// Avalon-MM requester bundle (one instance per requester).
//   master modport : the requester (drives command, receives response)
//   slave  modport : the arbiter   (receives command, drives response)
// Signals:
//   address, byteenable, read, write, writedata : command from requester
//   waitrequest                                  : command not accepted
//   readdata, readdatavalid                      : read response
// -----------------------------------------------------------------------------
interface onchip_mem_arbiter_if;
  import onchip_mem_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin grant. The grant is combinational from the
// requests and the registered pointer of the last winner; on contention the
// port that did not win last time is granted. The pointer only moves on a
// grant cycle, so idle cycles do not disturb fairness.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_req_a, i_req_b  : request from requester A / B
//   o_gnt_a, o_gnt_b  : one-hot (or zero) grant; forced low during reset
// -----------------------------------------------------------------------------
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  grant_t r_last_gnt;

  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (!reset) begin
      if (i_req_a && i_req_b) begin
        if (r_last_gnt == GNT_B) o_gnt_a = 1'b1;
        else                     o_gnt_b = 1'b1;
      end else begin
        o_gnt_a = i_req_a;
        o_gnt_b = i_req_b;
      end
    end
  end

  // Reset points at B so that A wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= GNT_B;
    end else if (o_gnt_a) begin
      r_last_gnt <= GNT_A;
    end else if (o_gnt_b) begin
      r_last_gnt <= GNT_B;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares a 4-word x 32-bit single-port RAM (1-cycle read latency) between two
// Avalon-MM requesters with round-robin fairness, one access per cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   a, b              : requester bundles (onchip_mem_arbiter_if.slave)
//   mem_address       : RAM word address
//   mem_byteenable    : RAM byte lanes
//   mem_chipselect    : RAM access strobe (high on grant cycles)
//   mem_write         : RAM write strobe
//   mem_writedata     : RAM write data
//   mem_clken         : RAM clock enable (low only during reset)
//   mem_readdata      : RAM read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  onchip_mem_arbiter_if.slave  a,
  onchip_mem_arbiter_if.slave  b,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BE_W-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_writedata,
  output logic                 mem_clken,
  input  logic [DATA_W-1:0]    mem_readdata
);

  avm_req_t w_req_a;
  avm_req_t w_req_b;
  avm_req_t w_sel;
  logic     w_valid_a;
  logic     w_valid_b;
  logic     w_gnt_a;
  logic     w_gnt_b;
  logic     w_gnt_any;

  logic     r_rd_pend_p1;
  grant_t   r_rd_sel_p1;

  assign w_req_a   = normalize_req(a.address, a.byteenable, a.read, a.write, a.writedata);
  assign w_req_b   = normalize_req(b.address, b.byteenable, b.read, b.write, b.writedata);
  assign w_valid_a = a.read | a.write;
  assign w_valid_b = b.read | b.write;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .i_req_a (w_valid_a),
    .i_req_b (w_valid_b),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign w_gnt_any = w_gnt_a | w_gnt_b;

  // ---- stage p0: grant cycle, command muxed onto the RAM ----
  // With no grant the A command is presented but chipselect stays low.
  always_comb begin
    w_sel          = w_gnt_b ? w_req_b : w_req_a;
    mem_address    = w_sel.address;
    mem_byteenable = w_sel.byteenable;
    mem_writedata  = w_sel.writedata;
    mem_chipselect = w_gnt_any;
    mem_write      = w_gnt_any & w_sel.write;
    mem_clken      = ~reset;
  end

  // Waitrequest is forced high during reset so no requester believes it
  // was accepted while the arbiter is not driving the RAM.
  assign a.waitrequest = reset | (w_valid_a & ~w_gnt_a);
  assign b.waitrequest = reset | (w_valid_b & ~w_gnt_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend_p1 <= 1'b0;
    end else begin
      r_rd_pend_p1 <= w_gnt_any & w_sel.read;
    end
  end

  always_ff @(posedge clk) begin
    r_rd_sel_p1 <= w_gnt_b ? GNT_B : GNT_A;
  end

  // ---- stage p1: RAM data returns, valid steered to the issuer ----
  // Gating with reset drops a read that was granted just before reset rose.
  assign a.readdatavalid = ~reset & r_rd_pend_p1 & (r_rd_sel_p1 == GNT_A);
  assign b.readdatavalid = ~reset & r_rd_pend_p1 & (r_rd_sel_p1 == GNT_B);
  assign a.readdata      = mem_readdata;
  assign b.readdata      = mem_readdata;

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the 4-word x 32-bit single-port on-chip RAM between two Avalon-MM requesters: port A (Nios II data master) and port B (hardware accelerator).
- Arbitrates each cycle with round-robin fairness and drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs.
- Routes the RAM's read data back to the requester that issued the read, using a fixed 1-cycle read-latency tracker.

Parameters:
ADDR_W, 2, word address width (RAM depth = 2**ADDR_W = 4)
DATA_W, 32, data width
BE_W, DATA_W/8 = 4, byteenable width

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-high reset
a_address  in  ADDR_W  requester A word address
a_byteenable  in  BE_W  requester A byte lanes
a_read  in  1  requester A read request
a_write  in  1  requester A write request
a_writedata  in  DATA_W  requester A write data
a_waitrequest  out  1  high = A request not accepted this cycle
a_readdata  out  DATA_W  read data returned to A
a_readdatavalid  out  1  a_readdata valid this cycle
b_*  (same eight signals as a_*, for requester B)
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken
mem_readdata  in  DATA_W  from RAM readdata (unregistered output, valid the cycle after address)

Behaviour:
- Request: req_X = X_read | X_write. If X_read and X_write are both high, treat as a write.
- Avalon rule: a master holds its request stable while X_waitrequest = 1.
- Grant is combinational from req_A, req_B and the registered pointer last_gnt (GNT_A / GNT_B).
  - Only one request: grant it.
  - Both request: grant the port that is NOT last_gnt.
  - No request: no grant; mem_chipselect = 0.
- Pointer: on any grant cycle, last_gnt <= granted port. It holds when idle.
- waitrequest: X_waitrequest = req_X & ~gnt_X. It is low when X is idle.
- RAM drive during a grant cycle:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted port.
  - mem_chipselect = 1; mem_write = granted port's write.
  - With no grant, mem_* hold the port-A values and mem_chipselect = 0.
- mem_clken = ~reset, so it is 1 in normal operation.
- Writes complete in the grant cycle, with no response phase.
- Read tracking:
  - Registers: rd_pend <= granted read; rd_sel <= granted port.
  - The cycle after the grant: X_readdatavalid = rd_pend & (rd_sel == X).
  - a_readdata and b_readdata both present mem_readdata; only readdatavalid is steered.
- Throughput: one access per cycle; back-to-back reads from the same port pipeline fully.
- Simultaneous steady requests from both ports alternate A, B, A, B, ...; no starvation, worst-case wait 1 cycle.
- Read-after-write to the same address: the arbiter never overlaps a read and a write in one cycle, so RAM read-during-write mode is irrelevant.
- Reset (synchronous):
  - last_gnt <= GNT_B, so A wins the first contention.
  - rd_pend <= 0.
  - While reset = 1: both waitrequest = 1, mem_chipselect = 0, mem_write = 0, mem_clken = 0, both readdatavalid = 0.
- Reset mid-operation: a read granted in the cycle reset asserts produces no readdatavalid. After reset deasserts, the first request is served in the same cycle.

Decomposition:
- Package onchip_mem_arb_pkg:
  - ADDR_W, DATA_W, BE_W constants.
  - enum grant_t {GNT_A, GNT_B}.
  - struct avm_req_t {address, byteenable, read, write, writedata}.
- Sub-module rr_arb2: two-request round-robin grant logic plus last_gnt register.
- Top level: request mux, RAM drive, read-latency tracker and response steering.

Test Plan:
1. Reset, then A writes addr 1 = 0xDEADBEEF with be = 4'hF, then A reads addr 1 -> write accepted with a_waitrequest = 0; a_readdatavalid = 1 exactly one cycle after the read grant with a_readdata = 0xDEADBEEF; b_readdatavalid stays 0.
2. A and B both read in the first cycle after reset (A addr 0, B addr 2) -> A granted first while b_waitrequest = 1; B granted the next cycle; valids arrive on consecutive cycles steered correctly.
3. Both ports hold continuous reads for 8 cycles -> grants alternate A, B, A, B, ...; each port gets 4 grants and 4 readdatavalid pulses.
4. B writes addr 3 = 0x11223344 with be = 4'b0101 over a word previously written 0xFFFFFFFF, then reads it -> readdata = 0xFF22FF44.
5. A issues a read and reset asserts in its grant cycle -> no readdatavalid on either port; all waitrequest = 1 and mem_chipselect = 0 during reset; normal service resumes the cycle after reset deasserts.
6. A issues 4 back-to-back reads of addr 0-3 with B idle -> zero waitrequest cycles; 4 consecutive valids in address order.
